// File: rtl/gmii_tx_nibble_adapter.sv
// MAC byte stream to GMII TX: byte pass-through at 1G, low/high nibble split at 10/100.
// One clk from a gmii_txc_en slot to the outputs; outputs hold between slots.
module gmii_tx_nibble_adapter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             speed_10_100,
    input  logic             client_txc_en,
    input  logic             gmii_txc_en,
    input  logic [7:0]       mac_txd,
    input  logic             mac_tx_en,
    input  logic             mac_tx_er,
    output logic [7:0]       gmii_txd,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic             tx_busy,
    output logic             align_err,
    output logic [CNT_W-1:0] tx_frame_cnt
);

    typedef enum logic [1:0] {IDLE, G_DATA, N_LO, N_HI} state_t;

    state_t     state, state_nxt;
    logic       mode, mode_nxt;          // 1 = nibble mode
    logic [7:0] cap_dat, cap_dat_nxt;
    logic       cap_er, cap_er_nxt;
    logic [7:0] txd_nxt;
    logic       tx_en_nxt, tx_er_nxt;
    logic       align_nxt;
    logic       byte_slot;
    logic       frame_end;

    assign byte_slot = client_txc_en & gmii_txc_en;
    assign frame_end = gmii_tx_en & ~tx_en_nxt;

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode;
        cap_dat_nxt = cap_dat;
        cap_er_nxt  = cap_er;
        txd_nxt     = gmii_txd;
        tx_en_nxt   = gmii_tx_en;
        tx_er_nxt   = gmii_tx_er;
        // A MAC strobe outside a GMII slot cannot be placed; its byte is lost.
        align_nxt   = align_err | (client_txc_en & ~gmii_txc_en);

        if (gmii_txc_en) begin
            case (state)
                IDLE: begin
                    txd_nxt   = 8'h00;
                    tx_en_nxt = 1'b0;
                    tx_er_nxt = 1'b0;
                    if (byte_slot && mac_tx_en) begin
                        cap_dat_nxt = mac_txd;
                        cap_er_nxt  = mac_tx_er;
                        tx_en_nxt   = 1'b1;
                        tx_er_nxt   = mac_tx_er;
                        if (mode) begin
                            state_nxt = N_LO;
                            txd_nxt   = {mac_txd[3:0], mac_txd[3:0]};
                        end else begin
                            state_nxt = G_DATA;
                            txd_nxt   = mac_txd;
                        end
                    end else if (byte_slot) begin
                        // Speed only takes effect between frames.
                        mode_nxt = speed_10_100;
                    end
                end
                G_DATA: begin
                    if (byte_slot) begin
                        if (mac_tx_en) begin
                            txd_nxt   = mac_txd;
                            tx_en_nxt = 1'b1;
                            tx_er_nxt = mac_tx_er;
                        end else begin
                            txd_nxt   = 8'h00;
                            tx_en_nxt = 1'b0;
                            tx_er_nxt = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
                N_LO: begin
                    txd_nxt   = {cap_dat[7:4], cap_dat[7:4]};
                    tx_en_nxt = 1'b1;
                    tx_er_nxt = cap_er;
                    state_nxt = N_HI;
                end
                N_HI: begin
                    txd_nxt   = 8'h00;
                    tx_en_nxt = 1'b0;
                    tx_er_nxt = 1'b0;
                    state_nxt = IDLE;
                    if (!client_txc_en) begin
                        align_nxt = 1'b1;
                    end else if (mac_tx_en) begin
                        cap_dat_nxt = mac_txd;
                        cap_er_nxt  = mac_tx_er;
                        txd_nxt     = {mac_txd[3:0], mac_txd[3:0]};
                        tx_en_nxt   = 1'b1;
                        tx_er_nxt   = mac_tx_er;
                        state_nxt   = N_LO;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mode         <= 1'b0;
            cap_dat      <= 8'h00;
            cap_er       <= 1'b0;
            gmii_txd     <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            tx_busy      <= 1'b0;
            align_err    <= 1'b0;
            tx_frame_cnt <= '0;
        end else begin
            state      <= state_nxt;
            mode       <= mode_nxt;
            cap_dat    <= cap_dat_nxt;
            cap_er     <= cap_er_nxt;
            gmii_txd   <= txd_nxt;
            gmii_tx_en <= tx_en_nxt;
            gmii_tx_er <= tx_er_nxt;
            tx_busy    <= (state_nxt != IDLE);
            align_err  <= align_nxt;
            if (frame_end) begin
                tx_frame_cnt <= tx_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_nibble_adapter.sv
// Directed bench: frame-level expected stream per GMII slot, checked every cycle, plus literal spot checks.
module tb_gmii_tx_nibble_adapter;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             speed_10_100;
    logic             client_txc_en;
    logic             gmii_txc_en;
    logic [7:0]       mac_txd;
    logic             mac_tx_en;
    logic             mac_tx_er;
    logic [7:0]       gmii_txd;
    logic             gmii_tx_en;
    logic             gmii_tx_er;
    logic             tx_busy;
    logic             align_err;
    logic [CNT_W-1:0] tx_frame_cnt;

    gmii_tx_nibble_adapter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .speed_10_100(speed_10_100),
        .client_txc_en(client_txc_en), .gmii_txc_en(gmii_txc_en),
        .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_er(mac_tx_er),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .tx_busy(tx_busy), .align_err(align_err), .tx_frame_cnt(tx_frame_cnt)
    );

    always #4 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]       exp_q[$];    // {txd, er} expected on each tx_en slot
    logic [8:0]       seen[$];     // {txd, er} observed on each tx_en slot
    logic [7:0]       frame_q[$];
    logic             mdl_mode = 1'b0;
    logic [CNT_W-1:0] mdl_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic c, input logic g, input logic [7:0] d, input logic e, input logic r);
        @(negedge clk);
        client_txc_en = c;
        gmii_txc_en   = g;
        mac_txd       = d;
        mac_tx_en     = e;
        mac_tx_er     = r;
    endtask

    task automatic slot(input int div, input logic c, input logic [7:0] d, input logic e, input logic r);
        for (int i = 0; i < div - 1; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(c, 1'b1, d, e, r);
    endtask

    // One MAC byte period: the byte slot, then the nibble-only slot when divided.
    task automatic mac_byte(input int div, input logic [7:0] d, input logic e, input logic r);
        slot(div, 1'b1, d, e, r);
        if (div > 1) slot(div, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic idle(input int div, input int n);
        for (int i = 0; i < n; i++) mac_byte(div, 8'h00, 1'b0, 1'b0);
        mdl_mode = speed_10_100;
    endtask

    task automatic send_frame(input int div, input int er_idx, input int tog_idx);
        for (int i = 0; i < frame_q.size(); i++) begin
            logic       r;
            logic [7:0] b;
            r = (i == er_idx);
            b = frame_q[i];
            if (i == tog_idx) speed_10_100 = ~speed_10_100;
            if (mdl_mode) begin
                exp_q.push_back({b[3:0], b[3:0], r});
                exp_q.push_back({b[7:4], b[7:4], r});
            end else begin
                exp_q.push_back({b, r});
            end
            mac_byte(div, b, 1'b1, r);
        end
        mac_byte(div, 8'h00, 1'b0, 1'b0);
    endtask

    logic       slot_now, rst_now;
    logic [9:0] prev_out = '0;
    logic       prev_en = 1'b0;

    always begin
        @(posedge clk);
        slot_now = gmii_txc_en;
        rst_now  = reset;
        #1;
        if (!rst_now) begin
            if (slot_now) begin
                if (gmii_tx_en) begin
                    seen.push_back({gmii_txd, gmii_tx_er});
                    if (exp_q.size() == 0)
                        check("tx_unexpected", 32'({gmii_txd, gmii_tx_er}), 32'h200);
                    else
                        check("tx_stream", 32'({gmii_txd, gmii_tx_er}), 32'(exp_q.pop_front()));
                end else begin
                    check("idle_zero", 32'({gmii_txd, gmii_tx_er}), 32'h0);
                    if (prev_en) mdl_cnt = mdl_cnt + 1'b1;
                end
            end else begin
                check("hold", 32'({gmii_txd, gmii_tx_en, gmii_tx_er}), 32'(prev_out));
            end
            check("frame_cnt", 32'(tx_frame_cnt), 32'(mdl_cnt));
            check("busy", 32'(tx_busy), 32'(gmii_tx_en));
        end
        prev_out = {gmii_txd, gmii_tx_en, gmii_tx_er};
        prev_en  = gmii_tx_en;
    end

    initial begin
        reset = 1'b1; speed_10_100 = 1'b0;
        client_txc_en = 1'b0; gmii_txc_en = 1'b0;
        mac_txd = 8'h00; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'({gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, align_err}), 32'h0);
        check("rst_cnt", 32'(tx_frame_cnt), 32'h0);
        reset = 1'b0;

        // 1G: preamble, SFD, 0x01..0x3C with both strobes held high
        idle(1, 3);
        frame_q.delete();
        for (int i = 0; i < 7; i++) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        for (int i = 1; i <= 60; i++) frame_q.push_back(8'(i));
        seen.delete();
        send_frame(1, -1, -1);
        idle(1, 3);
        check("g1_len", 32'(seen.size()), 32'd68);
        check("g1_first", 32'(seen[0]), 32'({8'h55, 1'b0}));
        check("g1_sfd", 32'(seen[7]), 32'({8'hD5, 1'b0}));
        check("g1_last", 32'(seen[67]), 32'({8'h3C, 1'b0}));
        check("g1_cnt", 32'(tx_frame_cnt), 32'd1);

        // 100M: D5, A7 -> 55 DD 77 AA
        speed_10_100 = 1'b1;
        idle(5, 2);
        frame_q = '{8'hD5, 8'hA7};
        seen.delete();
        send_frame(5, -1, -1);
        idle(5, 2);
        check("m100_len", 32'(seen.size()), 32'd4);
        check("m100_s0", 32'(seen[0]), 32'({8'h55, 1'b0}));
        check("m100_s1", 32'(seen[1]), 32'({8'hDD, 1'b0}));
        check("m100_s2", 32'(seen[2]), 32'({8'h77, 1'b0}));
        check("m100_s3", 32'(seen[3]), 32'({8'hAA, 1'b0}));

        // 10M: error on the 3rd byte -> er on slots 5 and 6 only
        idle(50, 1);
        frame_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        seen.delete();
        send_frame(50, 2, -1);
        idle(50, 1);
        check("m10_len", 32'(seen.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            check("m10_er", 32'(seen[i][0]), 32'((i == 4) || (i == 5)));

        // Speed toggled mid-frame: frame stays nibble, next one is byte mode
        idle(5, 2);
        frame_q = '{8'h12, 8'h34, 8'h56};
        seen.delete();
        send_frame(5, -1, 1);
        check("tog_len", 32'(seen.size()), 32'd6);
        check("tog_hi", 32'(seen[1]), 32'({8'h11, 1'b0}));
        idle(1, 3);
        frame_q = '{8'h12, 8'h34};
        seen.delete();
        send_frame(1, -1, -1);
        idle(1, 2);
        check("tog_g_len", 32'(seen.size()), 32'd2);
        check("tog_g_b0", 32'(seen[0]), 32'({8'h12, 1'b0}));

        // MAC strobe without a GMII slot
        check("align_pre", 32'(align_err), 32'h0);
        seen.delete();
        cyc(1'b1, 1'b0, 8'hAB, 1'b1, 1'b0);
        idle(1, 3);
        check("align_set", 32'(align_err), 32'h1);
        frame_q = '{8'h77};
        send_frame(1, -1, -1);
        idle(1, 2);
        check("align_sticky", 32'(align_err), 32'h1);
        check("align_len", 32'(seen.size()), 32'd1);

        // Reset while in N_HI
        speed_10_100 = 1'b1;
        idle(1, 1);
        idle(5, 1);
        exp_q.push_back({8'hCC, 1'b0});
        exp_q.push_back({8'h33, 1'b0});
        mac_byte(5, 8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        check("nhi_txd", 32'({gmii_txd, gmii_tx_en}), 32'({8'h33, 1'b1}));
        reset = 1'b1; gmii_txc_en = 1'b0; client_txc_en = 1'b0; mac_tx_en = 1'b0;
        exp_q.delete();
        mdl_cnt = '0;
        mdl_mode = 1'b0;
        @(posedge clk); #1;
        check("rst_nhi_outs", 32'({gmii_txd, gmii_tx_en, gmii_tx_er, tx_busy, align_err}), 32'h0);
        check("rst_nhi_cnt", 32'(tx_frame_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Counter wrap with minimal 1-byte frames
        speed_10_100 = 1'b0;
        idle(1, 2);
        frame_q = '{8'h5A};
        for (int k = 0; k < (1 << CNT_W) - 1; k++) send_frame(1, -1, -1);
        idle(1, 1);
        @(negedge clk);
        check("wrap_top", 32'(tx_frame_cnt), 32'((1 << CNT_W) - 1));
        send_frame(1, -1, -1);
        idle(1, 1);
        @(negedge clk);
        check("wrap_zero", 32'(tx_frame_cnt), 32'h0);

        idle(1, 2);
        check("exp_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
